// File: rtl/msrv32_pc_gen_stage.sv
// Program-counter generation stage: next-PC source selection and the PC register
// that feeds the word-aligned instruction fetch address to the AHB port.
module msrv32_pc_gen_stage #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input  logic        ms_risc32_mp_clk_in,
  input  logic        ms_risc32_mp_rst_in,
  input  logic [1:0]  pc_src_in,
  input  logic [31:0] epc_in,
  input  logic [31:0] trap_address_in,
  input  logic        branch_taken_in,
  input  logic [31:0] iaddr_in,
  input  logic        ahb_ready_in,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus_4_out,
  output logic [31:0] pc_mux_out,
  output logic [31:0] iaddr_out,
  output logic        misaligned_instr_logic_out
);

  typedef enum logic [1:0] {
    SRC_BOOT  = 2'b00,
    SRC_EPC   = 2'b01,
    SRC_TRAP  = 2'b10,
    SRC_NEXT  = 2'b11
  } pc_src_e;

  logic [31:0] pcQ;
  logic [31:0] pcD;
  logic [31:0] branchTarget;
  logic [31:0] nextPc;
  logic [31:0] pcMux;
  pc_src_e     pcSrc;

  assign pcSrc         = pc_src_e'(pc_src_in);
  assign pc_plus_4_out = pcQ + 32'd4;

  // JALR semantics: bit 0 of any branch/jump target is discarded.
  assign branchTarget = iaddr_in & 32'hFFFF_FFFE;
  assign nextPc       = branch_taken_in ? branchTarget : pc_plus_4_out;

  assign misaligned_instr_logic_out = branch_taken_in & nextPc[1];

  always_comb begin
    pcMux = BOOT_ADDRESS;
    unique case (pcSrc)
      SRC_BOOT: pcMux = BOOT_ADDRESS;
      SRC_EPC:  pcMux = epc_in;
      SRC_TRAP: pcMux = trap_address_in;
      SRC_NEXT: pcMux = nextPc;
      default:  pcMux = BOOT_ADDRESS;
    endcase
  end

  assign pc_mux_out = pcMux;

  always_comb begin
    pcD = pcQ;
    if (ahb_ready_in) begin
      pcD = pcMux;
    end
  end

  always_ff @(posedge ms_risc32_mp_clk_in) begin
    if (ms_risc32_mp_rst_in) begin
      pcQ <= BOOT_ADDRESS;
    end else begin
      pcQ <= pcD;
    end
  end

  assign pc_out = pcQ;

  // The fetch address is word aligned; the PC keeps the raw value so misalignment stays visible.
  assign iaddr_out = ms_risc32_mp_rst_in ? BOOT_ADDRESS : {pcMux[31:2], 2'b00};

endmodule

// File: tb/tb_msrv32_pc_gen_stage.sv
// Self-checking bench for msrv32_pc_gen_stage: directed scenarios, then randomized
// cycles compared against an arithmetic reference model of the PC stage.
module tb_msrv32_pc_gen_stage;

  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic        clock;
  logic        reset;
  logic [1:0]  pcSrc;
  logic [31:0] epc;
  logic [31:0] trapAddr;
  logic        branchTaken;
  logic [31:0] iaddrIn;
  logic        ahbReady;
  logic [31:0] pcOut;
  logic [31:0] pcPlus4;
  logic [31:0] pcMux;
  logic [31:0] iaddrOut;
  logic        misaligned;

  int vectorCount = 0;
  int missCount   = 0;

  logic [31:0] modelPc;
  bit          modelValid = 0;

  msrv32_pc_gen_stage #(.BOOT_ADDRESS(BOOT)) dut (
    .ms_risc32_mp_clk_in        (clock),
    .ms_risc32_mp_rst_in        (reset),
    .pc_src_in                  (pcSrc),
    .epc_in                     (epc),
    .trap_address_in            (trapAddr),
    .branch_taken_in            (branchTaken),
    .iaddr_in                   (iaddrIn),
    .ahb_ready_in               (ahbReady),
    .pc_out                     (pcOut),
    .pc_plus_4_out              (pcPlus4),
    .pc_mux_out                 (pcMux),
    .iaddr_out                  (iaddrOut),
    .misaligned_instr_logic_out (misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drives one cycle's inputs at the falling edge, checks the combinational view
  // against the model, then advances the model to what the next rising edge does.
  task automatic applyStimulus(input logic rst, input logic [1:0] src, input logic [31:0] epcV,
                               input logic [31:0] trapV, input logic br, input logic [31:0] tgt,
                               input logic rdy);
    logic [31:0] expSeq;
    logic [31:0] expNext;
    logic [31:0] expMux;
    logic        expMis;
    @(negedge clock);
    reset = rst; pcSrc = src; epc = epcV; trapAddr = trapV;
    branchTaken = br; iaddrIn = tgt; ahbReady = rdy;
    #1;
    expSeq  = modelPc + 32'd4;
    expNext = br ? (tgt / 2) * 2 : expSeq;
    expMis  = br && ((expNext % 4) >= 2);
    case (src)
      2'd0:    expMux = BOOT;
      2'd1:    expMux = epcV;
      2'd2:    expMux = trapV;
      default: expMux = expNext;
    endcase
    checkOutput("misaligned", {31'd0, misaligned}, {31'd0, expMis});
    if (modelValid) begin
      checkOutput("pc_out", pcOut, modelPc);
      checkOutput("pc_plus_4", pcPlus4, expSeq);
      checkOutput("pc_mux", pcMux, expMux);
    end else if (src != 2'd3) begin
      checkOutput("pc_mux", pcMux, expMux);
    end
    if (rst) begin
      checkOutput("iaddr_rst", iaddrOut, BOOT);
    end else if (modelValid || src != 2'd3) begin
      checkOutput("iaddr", iaddrOut, expMux - (expMux % 4));
    end
    if (rst) begin
      modelPc    = BOOT;
      modelValid = 1;
    end else if (rdy && modelValid) begin
      modelPc = expMux;
    end
  endtask

  initial begin
    reset = 1'b1; pcSrc = 2'd3; epc = '0; trapAddr = '0;
    branchTaken = 1'b0; iaddrIn = '0; ahbReady = 1'b1;

    applyStimulus(1, 2'd3, 0, 0, 0, 0, 1);
    applyStimulus(0, 2'd3, 0, 0, 0, 0, 1);
    applyStimulus(0, 2'd3, 0, 0, 0, 0, 1);
    applyStimulus(0, 2'd3, 0, 0, 0, 0, 1);
    applyStimulus(0, 2'd3, 0, 0, 1, 32'h1122_3344, 1);
    applyStimulus(0, 2'd3, 0, 0, 1, 32'h1122_3347, 1);
    applyStimulus(0, 2'd1, 32'hAABB_CCDD, 0, 0, 0, 1);
    applyStimulus(0, 2'd2, 0, 32'h1122_3344, 0, 0, 1);
    applyStimulus(0, 2'd0, 0, 0, 1, 32'h0000_0006, 1);
    applyStimulus(0, 2'd2, 0, 0, 1, 32'h0000_0002, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 2'd3, 0, 0, 0, 0, 0);
    applyStimulus(0, 2'd3, 0, 0, 0, 0, 1);
    applyStimulus(0, 2'd3, 0, 0, 0, 0, 1);
    applyStimulus(0, 2'd3, 0, 0, 1, 32'hFFFF_FFFC, 1);
    applyStimulus(0, 2'd3, 0, 0, 0, 0, 1);
    applyStimulus(0, 2'd3, 0, 0, 0, 0, 1);
    applyStimulus(0, 2'd3, 0, 0, 0, 0, 1);
    applyStimulus(1, 2'd1, 32'h1234_5678, 0, 0, 0, 0);
    applyStimulus(0, 2'd3, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0));
    end

    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
